// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_pkg
// Description : Shared raster-timing constants for the VGA sync generator.
//               Holds the default 640x480@60 porch/sync/active values, the
//               derived line/frame totals and the coordinate width.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    // Coordinate counters are 10 bits wide, so no total may exceed 1024.
    localparam int COORD_W   = 10;
    localparam int MAX_TOTAL = 1 << COORD_W;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;

    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Sum of the four segments of one axis (active + porches + sync).
    function automatic int axis_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int DEF_H_TOTAL = axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int DEF_V_TOTAL = axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage
`default_nettype wire

// File: rtl/pixel_tick.sv
`default_nettype none
// ============================================================================
// Module      : pixel_tick
// Description : Pixel-rate enable for the raster counters.
//               Compile-time option PIXEL_DIV_EN:
//                 defined   - divide-by-2 phase register; tick = (phase == 1),
//                             so the first tick is on the second CLK after
//                             reset release.
//                 undefined - tick is constant 1, no state.
// Ports       : CLK  in  1  system clock
//               RST  in  1  asynchronous active-low reset
//               tick out 1  counter advance enable
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_tick (
    input  logic CLK,
    input  logic RST,
    output logic tick
);

`ifdef PIXEL_DIV_EN
    logic r_phase;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_phase <= 1'b0;
        end else begin
            r_phase <= ~r_phase;
        end
    end

    assign tick = r_phase;
`else
    // Clock and reset are not needed without the divider; fold them into a
    // sink so the ports stay in place for both builds.
    logic w_unused;
    assign w_unused = &{1'b0, CLK, RST};

    assign tick = 1'b1;
`endif

endmodule
`default_nettype wire

// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_sync_gen
// Description : Raster timing generator. Produces pixel coordinates,
//               blanking flags, active-low sync pulses and a one-CLK
//               frame_start pulse. All outputs are registered and decoded
//               from the next counter values so they change on the same
//               edge as the counters, with no skew between them.
//               Compile-time option PIXEL_DIV_EN (in pixel_tick): counters
//               advance on every second CLK instead of every CLK.
// Ports       : CLK         in  1   system clock
//               RST         in  1   asynchronous active-low reset
//               col         out 10  horizontal counter 0..H_TOTAL-1
//               row         out 10  vertical counter 0..V_TOTAL-1
//               hnotactive  out 1   col >= H_ACTIVE
//               vnotactive  out 1   row >= V_ACTIVE
//               hsync       out 1   active-low horizontal sync
//               vsync       out 1   active-low vertical sync
//               frame_start out 1   one-CLK pulse on wrap to (0,0)
// Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic               CLK,
    input  logic               RST,
    output logic [COORD_W-1:0] col,
    output logic [COORD_W-1:0] row,
    output logic               hnotactive,
    output logic               vnotactive,
    output logic               hsync,
    output logic               vsync,
    output logic               frame_start
);

    localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    // Decode is done one bit wider than the counters so a sync window that
    // ends exactly at a total of 1024 still compares correctly.
    localparam int EXT_W = COORD_W + 1;

    localparam logic [EXT_W-1:0] C_ONE      = EXT_W'(1);
    localparam logic [EXT_W-1:0] C_H_LAST   = EXT_W'(H_TOTAL - 1);
    localparam logic [EXT_W-1:0] C_H_ACT    = EXT_W'(H_ACTIVE);
    localparam logic [EXT_W-1:0] C_HS_START = EXT_W'(H_ACTIVE + H_FP);
    localparam logic [EXT_W-1:0] C_HS_END   = EXT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [EXT_W-1:0] C_V_LAST   = EXT_W'(V_TOTAL - 1);
    localparam logic [EXT_W-1:0] C_V_ACT    = EXT_W'(V_ACTIVE);
    localparam logic [EXT_W-1:0] C_VS_START = EXT_W'(V_ACTIVE + V_FP);
    localparam logic [EXT_W-1:0] C_VS_END   = EXT_W'(V_ACTIVE + V_FP + V_SYNC);

    // Refuse to build a raster the 10-bit counters cannot represent.
    if (H_TOTAL > MAX_TOTAL) begin : g_h_total_too_big
        $error("vga_sync_gen: H_TOTAL %0d exceeds %0d", H_TOTAL, MAX_TOTAL);
    end
    if (V_TOTAL > MAX_TOTAL) begin : g_v_total_too_big
        $error("vga_sync_gen: V_TOTAL %0d exceeds %0d", V_TOTAL, MAX_TOTAL);
    end

    logic             w_tick;
    logic [EXT_W-1:0] w_col_cur;
    logic [EXT_W-1:0] w_row_cur;
    logic [EXT_W-1:0] w_col_nxt;
    logic [EXT_W-1:0] w_row_nxt;
    logic             w_frame_wrap;

    pixel_tick u_pixel_tick (
        .CLK  (CLK),
        .RST  (RST),
        .tick (w_tick)
    );

    assign w_col_cur = {1'b0, col};
    assign w_row_cur = {1'b0, row};

    // Next-coordinate computation; counters hold on tick-less CLKs.
    always_comb begin
        w_col_nxt    = w_col_cur;
        w_row_nxt    = w_row_cur;
        w_frame_wrap = 1'b0;
        if (w_tick) begin
            if (w_col_cur == C_H_LAST) begin
                w_col_nxt = '0;
                if (w_row_cur == C_V_LAST) begin
                    w_row_nxt    = '0;
                    w_frame_wrap = 1'b1;
                end else begin
                    w_row_nxt = w_row_cur + C_ONE;
                end
            end else begin
                w_col_nxt = w_col_cur + C_ONE;
            end
        end
    end

    // Flags are decoded from the next values so they land on the same edge
    // as the counters. vsync depends only on row, which changes only at the
    // col wrap, so it naturally transitions at col = 0.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            col         <= '0;
            row         <= '0;
            hnotactive  <= 1'b0;
            vnotactive  <= 1'b0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            col         <= w_col_nxt[COORD_W-1:0];
            row         <= w_row_nxt[COORD_W-1:0];
            hnotactive  <= (w_col_nxt >= C_H_ACT);
            vnotactive  <= (w_row_nxt >= C_V_ACT);
            hsync       <= !((w_col_nxt >= C_HS_START) && (w_col_nxt < C_HS_END));
            vsync       <= !((w_row_nxt >= C_VS_START) && (w_row_nxt < C_VS_END));
            frame_start <= w_frame_wrap;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_sync_gen
// Description : Directed testbench for vga_sync_gen. A default-parameter
//               instance covers reset and line timing; a miniature raster
//               (16 x 12) covers frame-level timing and mid-frame reset so
//               full frames fit in a short run. Expected periods scale by
//               the pixel divider when PIXEL_DIV_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_sync_gen;

`ifdef PIXEL_DIV_EN
    localparam int DIV = 2;
`else
    localparam int DIV = 1;
`endif

    // Miniature raster: H 8+2+3+3 = 16, V 6+2+2+2 = 12, frame = 192 ticks.
    localparam int HT_S = 16;
    localparam int VT_S = 12;
    localparam int F_S  = HT_S * VT_S;

    logic       clk = 1'b0;
    logic       rst_n;
    int         cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;

    logic [9:0] col_d, row_d, col_s, row_s;
    logic       hn_d, vn_d, hs_d, vs_d, fs_d;
    logic       hn_s, vn_s, hs_s, vs_s, fs_s;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vga_sync_gen dut (
        .CLK(clk), .RST(rst_n), .col(col_d), .row(row_d),
        .hnotactive(hn_d), .vnotactive(vn_d), .hsync(hs_d), .vsync(vs_d),
        .frame_start(fs_d)
    );

    vga_sync_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2)
    ) dut_s (
        .CLK(clk), .RST(rst_n), .col(col_s), .row(row_s),
        .hnotactive(hn_s), .vnotactive(vn_s), .hsync(hs_s), .vsync(vs_s),
        .frame_start(fs_s)
    );

    localparam logic [24:0] RESET_VEC = {10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({col_d, row_d, hn_d, vn_d, hs_d, vs_d, fs_d} !== RESET_VEC) begin
            miscompares++;
            $display("FAIL reset_default: got %h expected %h",
                     {col_d, row_d, hn_d, vn_d, hs_d, vs_d, fs_d}, RESET_VEC);
        end
        vectors++;
        if ({col_s, row_s, hn_s, vn_s, hs_s, vs_s, fs_s} !== RESET_VEC) begin
            miscompares++;
            $display("FAIL reset_small: got %h expected %h",
                     {col_s, row_s, hn_s, vn_s, hs_s, vs_s, fs_s}, RESET_VEC);
        end
        rst_n = 1'b1;
        repeat (DIV) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (col_d !== 10'd1 || row_d !== 10'd0 || fs_d !== 1'b0) begin
            miscompares++;
            $display("FAIL first_advance: col=%0d row=%0d fs=%b expected col=1 row=0 fs=0",
                     col_d, row_d, fs_d);
        end
    endtask

    task automatic test_line();
        logic [9:0] pc = col_d, pr = row_d;
        logic       phn = hn_d, phs = hs_d;
        int         fall_cyc = -1, changes = 0;
        bit         seen_hn = 0, seen_fall = 0, seen_rise = 0, seen_wrap = 0;
        for (int i = 0; i < (800 + 10) * DIV; i++) begin
            @(negedge clk);
            if (i < 20 * DIV && col_d != pc) changes++;
            if (hn_d && !phn) begin
                seen_hn = 1; vectors++;
                if (col_d !== 10'd640) begin
                    miscompares++;
                    $display("FAIL hnotactive_rise: col=%0d expected 640", col_d);
                end
            end
            if (!hs_d && phs) begin
                seen_fall = 1; fall_cyc = cyc; vectors++;
                if (col_d !== 10'd656) begin
                    miscompares++;
                    $display("FAIL hsync_fall: col=%0d expected 656", col_d);
                end
            end
            if (hs_d && !phs) begin
                seen_rise = 1; vectors++;
                if (col_d !== 10'd752 || cyc - fall_cyc !== 96 * DIV) begin
                    miscompares++;
                    $display("FAIL hsync_rise: col=%0d width=%0d expected col=752 width=%0d",
                             col_d, cyc - fall_cyc, 96 * DIV);
                end
            end
            if (col_d != pc && col_d == 10'd0) begin
                seen_wrap = 1; vectors++;
                if (pc !== 10'd799 || row_d !== pr + 10'd1) begin
                    miscompares++;
                    $display("FAIL line_wrap: prev_col=%0d row=%0d prev_row=%0d expected 799 and row+1",
                             pc, row_d, pr);
                end
            end
            pc = col_d; pr = row_d; phn = hn_d; phs = hs_d;
        end
        vectors++;
        if (changes !== 20) begin
            miscompares++;
            $display("FAIL tick_rate: col changes=%0d expected 20", changes);
        end
        vectors++;
        if ({seen_hn, seen_fall, seen_rise, seen_wrap} !== 4'b1111) begin
            miscompares++;
            $display("FAIL line_events: seen=%b expected 1111",
                     {seen_hn, seen_fall, seen_rise, seen_wrap});
        end
    endtask

    task automatic test_frame();
        logic [9:0] pc = col_s, pr = row_s;
        logic       pvn = vn_s, pvs = vs_s, pfs = fs_s;
        int         last_fs = -1, vs_fall = -1, n_fs = 0, n_vs = 0, n_vn = 0;
        for (int i = 0; i < (3 * F_S + 10) * DIV; i++) begin
            @(negedge clk);
            vectors++;
            if (hn_s !== (col_s >= 10'd8) || vn_s !== (row_s >= 10'd6)) begin
                miscompares++;
                $display("FAIL blank_decode: col=%0d row=%0d hn=%b vn=%b", col_s, row_s, hn_s, vn_s);
            end
            if (fs_s) begin
                vectors++;
                if (pfs !== 1'b0 || col_s !== 10'd0 || row_s !== 10'd0 ||
                    pc !== 10'(HT_S - 1) || pr !== 10'(VT_S - 1)) begin
                    miscompares++;
                    $display("FAIL frame_start_pulse: prev_fs=%b at (%0d,%0d) from (%0d,%0d) expected single pulse at (0,0) from (%0d,%0d)",
                             pfs, row_s, col_s, pr, pc, VT_S - 1, HT_S - 1);
                end
                if (last_fs >= 0) begin
                    vectors++;
                    if (cyc - last_fs !== F_S * DIV) begin
                        miscompares++;
                        $display("FAIL frame_spacing: got %0d expected %0d", cyc - last_fs, F_S * DIV);
                    end
                end
                last_fs = cyc; n_fs++;
            end
            if (vn_s && !pvn) begin
                n_vn++; vectors++;
                if (row_s !== 10'd6 || col_s !== 10'd0) begin
                    miscompares++;
                    $display("FAIL vnotactive_rise: at (%0d,%0d) expected (6,0)", row_s, col_s);
                end
            end
            if (!vn_s && pvn) begin
                vectors++;
                if (row_s !== 10'd0 || col_s !== 10'd0) begin
                    miscompares++;
                    $display("FAIL vnotactive_fall: at (%0d,%0d) expected (0,0)", row_s, col_s);
                end
            end
            if (!vs_s && pvs) begin
                vs_fall = cyc; vectors++;
                if (row_s !== 10'd8 || col_s !== 10'd0) begin
                    miscompares++;
                    $display("FAIL vsync_fall: at (%0d,%0d) expected (8,0)", row_s, col_s);
                end
            end
            if (vs_s && !pvs && vs_fall >= 0) begin
                n_vs++; vectors++;
                if (cyc - vs_fall !== 2 * HT_S * DIV || row_s !== 10'd10) begin
                    miscompares++;
                    $display("FAIL vsync_width: got %0d row=%0d expected %0d row=10",
                             cyc - vs_fall, row_s, 2 * HT_S * DIV);
                end
            end
            pc = col_s; pr = row_s; pvn = vn_s; pvs = vs_s; pfs = fs_s;
        end
        vectors++;
        if (n_fs < 2 || n_vs < 2 || n_vn < 2) begin
            miscompares++;
            $display("FAIL frame_events: fs=%0d vsync=%0d vn=%0d expected at least 2 each", n_fs, n_vs, n_vn);
        end
    endtask

    task automatic test_mid_reset();
        bit found = 0;
        int t0;
        for (int i = 0; i < 2 * F_S * DIV && !found; i++) begin
            @(negedge clk);
            if (row_s == 10'd8 && col_s == 10'd11) found = 1;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL mid_reset_reach: point (8,11) not reached, at (%0d,%0d)", row_s, col_s);
            return;
        end
        // Assert between edges: outputs must clear without a CLK edge.
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({col_s, row_s, hn_s, vn_s, hs_s, vs_s, fs_s} !== RESET_VEC) begin
            miscompares++;
            $display("FAIL async_reset_small: got %h expected %h",
                     {col_s, row_s, hn_s, vn_s, hs_s, vs_s, fs_s}, RESET_VEC);
        end
        vectors++;
        if ({col_d, row_d, hn_d, vn_d, hs_d, vs_d, fs_d} !== RESET_VEC) begin
            miscompares++;
            $display("FAIL async_reset_default: got %h expected %h",
                     {col_d, row_d, hn_d, vn_d, hs_d, vs_d, fs_d}, RESET_VEC);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        t0 = cyc;
        found = 0;
        for (int i = 0; i < (F_S + 10) * DIV && !found; i++) begin
            @(negedge clk);
            if (fs_s) found = 1;
        end
        vectors++;
        if (!found || cyc - t0 !== F_S * DIV) begin
            miscompares++;
            $display("FAIL restart_frame_start: found=%b after %0d CLK expected %0d", found, cyc - t0, F_S * DIV);
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_frame();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_sync_gen.md
# vga_sync_gen

Raster timing generator driving the display path. Produces the pixel coordinates (`row`, `col`), blanking flags and active-low sync pulses that the display/key-sampling logic consumes. `vnotactive` is the vertical-blanking window during which key sampling and mode changes take place. It sits between the board clock and the display block and is the single source of frame timing.

## Interface
Parameters:
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch (pixels).
- `H_SYNC`, 96: hsync pulse width (pixels).
- `H_BP`, 48: horizontal back porch (pixels).
- `V_ACTIVE`, 480: visible lines per frame.
- `V_FP`, 10: vertical front porch (lines).
- `V_SYNC`, 2: vsync pulse width (lines).
- `V_BP`, 33: vertical back porch (lines).

Ports:
- `CLK` in 1: system clock; one clock domain only.
- `RST` in 1: asynchronous, active-low reset.
- `col` out 10: horizontal counter, 0..H_TOTAL-1 (H_TOTAL = 800).
- `row` out 10: vertical counter, 0..V_TOTAL-1 (V_TOTAL = 525).
- `hnotactive` out 1: high when `col` >= H_ACTIVE.
- `vnotactive` out 1: high when `row` >= V_ACTIVE.
- `hsync` out 1: active-low horizontal sync.
- `vsync` out 1: active-low vertical sync.
- `frame_start` out 1: one-CLK pulse on the tick where the counters wrap to (0,0).

## Operation
- Pixel tick `tick`: every CLK by default. With the divider compiled in, see Configuration.
- On each tick:
  - `col` increments.
  - At H_TOTAL-1, `col` wraps to 0 and `row` increments.
  - At (H_TOTAL-1, V_TOTAL-1), both wrap to 0.
- Flags are decoded from the counters:
  - `hsync` = 0 for `col` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751.
  - `vsync` = 0 for `row` in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. 490..491.
  - `vsync` changes only together with a `row` change, at `col` = 0.
- Counters are 10-bit, unsigned, compared against parameter sums. Elaboration must fail if H_TOTAL or V_TOTAL exceeds 1024.
- Downstream sees every `vnotactive` window. Each 0→1 transition occurs exactly once per frame, at (`row`,`col`) = (480,0).

## Timing
- Reset values, while `RST` = 0 and immediately on assertion (asynchronous):
  - `col` = 0, `row` = 0.
  - `hnotactive` = 0, `vnotactive` = 0.
  - `hsync` = 1, `vsync` = 1.
  - `frame_start` = 0.
  - Divider phase = 0.
- All outputs are registered. The flags are computed from the next counter values, so every output changes on the same CLK edge as the counter it belongs to, with zero skew between outputs.
- First counter advance: on the first tick after `RST` deasserts. No `frame_start` is emitted for the reset state itself.
- `frame_start`:
  - Is high for exactly one CLK, on the edge where the counters become (0,0) from (799,524).
  - Is low on every other edge, including tick-less CLKs.
- Reset asserted mid-frame: all state returns to reset values asynchronously. The frame restarts from (0,0) with no partial sync pulse extension.
- Frame period: H_TOTAL×V_TOTAL = 420000 ticks.

## Configuration
- `PIXEL_DIV_EN`:
  - Defined: a divide-by-2 phase register gates `tick`, so counters advance on every second CLK. The phase resets to 0, toggles every CLK, and `tick` = phase==1. The first advance is on the second CLK after reset release. Frame period is 840000 CLK; `frame_start` remains a single-CLK pulse.
  - Undefined: `tick` is constant 1, the phase register is absent, and frame period is 420000 CLK.

## Structure
- Shared package `vga_timing_pkg`:
  - Default porch/sync/active constants.
  - Derived H_TOTAL/V_TOTAL.
  - Coordinate width constant (10).
- Sub-module `pixel_tick`: generates `tick`, containing the divider under `PIXEL_DIV_EN`.
- Counters and flag decode live in `vga_sync_gen`.

## Test plan
- Reset: hold `RST`=0 for 5 CLK → `col`=`row`=0, `hsync`=`vsync`=1, `hnotactive`=`vnotactive`=0, `frame_start`=0. Release → `col`=1 after the first CLK (no divider).
- Line timing (no divider):
  - `hnotactive` rises at `col`=640.
  - `hsync` falls at `col`=656 and rises at `col`=752.
  - `col` wraps 799→0 with `row` incrementing on the same edge.
- Frame timing:
  - `vnotactive` rises at (480,0) and falls at (0,0).
  - `vsync` is low for exactly 1600 CLK, starting at (490,0).
  - `frame_start` pulses are spaced exactly 420000 CLK apart.
- `PIXEL_DIV_EN` defined:
  - Counters hold on alternate CLKs.
  - `hsync` low width is 192 CLK.
  - `frame_start` spacing is 840000 CLK; each pulse is 1 CLK wide.
- Mid-frame reset: assert `RST` at (300,400) asynchronously between edges → outputs reach reset values without a CLK edge. After release, counting resumes from 0, and the next `frame_start` comes 420000 CLK later.
